synth_cmd_fifo: RTL and testbench

SYNTH_CMD_FIFO -- requirements
Module: synth_cmd_fifo

---
 rtl/synth_cmd_fifo_pkg.sv | 15 +
 rtl/synth_cmd_fifo.sv | 118 +++++++++++
 tb/tb_synth_cmd_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/synth_cmd_fifo_pkg.sv
// Shared constants and the command entry type for the synth command FIFO.
package synth_cmd_fifo_pkg;

    localparam int CTRL_W        = 8;
    localparam int DATA_W        = 8;
    localparam int CMD_W         = CTRL_W + DATA_W;
    localparam int DEFAULT_DEPTH = 16;

    // One stored command: control byte in the upper half, data byte in the lower half.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage : synth_cmd_fifo_pkg

// File: rtl/synth_cmd_fifo.sv
// First-word-fall-through command FIFO between synth_arb and its consumer.
// The head entry is read combinationally from the register array so that it
// is presented with no read latency; occupancy is tracked by a registered
// count from which full/empty are derived.
module synth_cmd_fifo
    import synth_cmd_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CTRL_W-1:0] synth_ctrl,
    input  logic [DATA_W-1:0] synth_data,
    output logic              fifo_full,
    input  logic              rd_en,
    output logic [CTRL_W-1:0] rd_ctrl,
    output logic [DATA_W-1:0] rd_data,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Storage is never reset; stale contents are unreachable once the
    // pointers and count return to zero.
    cmd_t              r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_accept;
    logic              w_wr_accept;
    logic              w_ovf_event;
    logic              w_unf_event;
    cmd_t              w_head;
    cmd_t              w_wr_entry;

    // Handshake qualification: a write into a full FIFO is still accepted when
    // a read frees the head slot on the same edge.
    always_comb begin
        w_full      = (r_count == FULL_COUNT);
        w_empty     = (r_count == '0);
        w_rd_accept = rd_en && !w_empty;
        w_wr_accept = wr_en && (!w_full || w_rd_accept);
        w_ovf_event = wr_en && !w_wr_accept;
        w_unf_event = rd_en && w_empty;
        w_wr_entry  = '{ctrl: synth_ctrl, data: synth_data};
        w_head      = r_mem[r_rd_ptr];
    end

    // Write port of the register array.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at ADDR_W bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a fresh error event beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_event) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_event) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Outputs: head entry falls through, forced to zero while empty.
    always_comb begin
        fifo_full  = w_full;
        fifo_empty = w_empty;
        fifo_count = r_count;
        overflow   = r_overflow;
        underflow  = r_underflow;
        rd_ctrl    = w_empty ? '0 : w_head.ctrl;
        rd_data    = w_empty ? '0 : w_head.data;
    end

endmodule : synth_cmd_fifo

// File: tb/tb_synth_cmd_fifo.sv
// Scoreboard bench for synth_cmd_fifo: expected entries are queued as writes
// are accepted and compared against the fall-through head when popped.
module tb_synth_cmd_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [7:0]        synth_ctrl;
    logic [7:0]        synth_data;
    logic              fifo_full;
    logic              rd_en;
    logic [7:0]        rd_ctrl;
    logic [7:0]        rd_data;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    int                n_assert;
    int                n_fail;
    logic [15:0]       sb_q[$];
    logic              m_ovf;
    logic              m_unf;

    synth_cmd_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .synth_ctrl (synth_ctrl),
        .synth_data (synth_data),
        .fifo_full  (fifo_full),
        .rd_en      (rd_en),
        .rd_ctrl    (rd_ctrl),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .underflow  (underflow),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the model state.
    task automatic check_outputs(input string tag);
        logic [15:0] head;
        head = (sb_q.size() == 0) ? 16'h0000 : sb_q[0];
        check_val({tag, ".count"}, 32'(fifo_count), 32'(sb_q.size()));
        check_val({tag, ".empty"}, 32'(fifo_empty), 32'(sb_q.size() == 0));
        check_val({tag, ".full"},  32'(fifo_full),  32'(sb_q.size() == DEPTH));
        check_val({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
        check_val({tag, ".unf"},   32'(underflow),  32'(m_unf));
        check_val({tag, ".rd"},    32'({rd_ctrl, rd_data}), 32'(head));
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input string tag, input bit wr, input logic [7:0] c,
                        input logic [7:0] d, input bit rd, input bit clr);
        bit rd_acc;
        bit wr_acc;
        bit ovf_ev;
        bit unf_ev;
        wr_en      = wr;
        synth_ctrl = c;
        synth_data = d;
        rd_en      = rd;
        clr_err    = clr;
        #1;
        rd_acc = rd && (sb_q.size() > 0);
        wr_acc = wr && ((sb_q.size() < DEPTH) || rd_acc);
        ovf_ev = wr && !wr_acc;
        unf_ev = rd && (sb_q.size() == 0);
        if (rd_acc) begin
            check_val({tag, ".pop"}, 32'({rd_ctrl, rd_data}), 32'(sb_q[0]));
            $display("pop  %s ctrl=%02h data=%02h", tag, rd_ctrl, rd_data);
        end
        @(posedge clk);
        #1;
        if (rd_acc) void'(sb_q.pop_front());
        if (wr_acc) sb_q.push_back({c, d});
        m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = unf_ev ? 1'b1 : (clr ? 1'b0 : m_unf);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        check_outputs(tag);
        $display("step %s wr=%0b rd=%0b clr=%0b ctrl=%02h data=%02h count=%0d", tag, wr, rd, clr, c, d, fifo_count);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        reset      = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        clr_err    = 1'b0;
        synth_ctrl = 8'h00;
        synth_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single write, visible the next cycle.
        step("single_wr", 1'b1, 8'h01, 8'h08, 1'b0, 1'b0);
        check_val("single.rd_ctrl", 32'(rd_ctrl), 32'h01);
        check_val("single.rd_data", 32'(rd_data), 32'h08);
        step("single_rd", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Fill to full, then a rejected 17th write.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 8'(8'hA0 + i), 1'b0, 1'b0);
        check_val("fill.full", 32'(fifo_full), 32'h1);
        step("wr17", 1'b1, 8'hEE, 8'hEE, 1'b0, 1'b0);
        check_val("wr17.ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step("clr_ovf", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous write and read: count stays at DEPTH.
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 8'(8'h40 + i), 8'(i), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'h11, 8'h0A, 1'b1, 1'b0);
        check_val("full_wr_rd.count", 32'(fifo_count), 32'(DEPTH));
        check_val("full_wr_rd.ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Underflow, clear, and error winning over clear.
        step("rd_empty", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("rd_empty.unf", 32'(underflow), 32'h1);
        step("clr_unf", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check_val("clr_unf.unf", 32'(underflow), 32'h0);
        step("unf_vs_clr", 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        step("wr_rd_empty", 1'b1, 8'h5A, 8'hC3, 1'b1, 1'b0);
        step("drain3", 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);

        // Asynchronous reset with five entries stored.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h70 + i), 8'(i), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        sb_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_outputs("async_rst");
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst_wr", 1'b1, 8'h02, 8'h33, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Interleaved pairs wrap the pointers several times.
        for (int i = 0; i < 40; i++) begin
            step("pair_wr", 1'b1, 8'(i * 3), 8'(8'hFF - i), 1'b0, 1'b0);
            check_val("pair.count_le1", 32'(fifo_count <= 1), 32'h1);
            step("pair_rd", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_synth_cmd_fifo
